// File: rtl/ghost_chase_ctrl.sv
// Ghost steering: scatter/chase mode timer, target chase with no-reverse,
// wall avoidance, minimum turn hold and catch detection, one step per frame.
module ghost_chase_ctrl #(
    parameter int SCATTER_FRAMES = 420,
    parameter int CHASE_FRAMES   = 1200,
    parameter int HOLD_FRAMES    = 8,
    parameter int CORNER_X       = 396,
    parameter int CORNER_Y       = 7,
    parameter int X_MIN          = 7,
    parameter int X_MAX          = 396,
    parameter int Y_MIN          = 7,
    parameter int Y_MAX          = 440
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       enable,
    input  logic [9:0] pacX,
    input  logic [9:0] pacY,
    input  logic [9:0] ghostX,
    input  logic [9:0] ghostY,
    input  logic [9:0] ghostS,
    output logic [7:0] dir_code,
    output logic [1:0] mode,
    output logic       catch
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCATTER = 2'd1,
        CHASE   = 2'd2
    } mode_t;

    localparam logic [7:0] DIR_L = 8'h04;
    localparam logic [7:0] DIR_R = 8'h07;
    localparam logic [7:0] DIR_D = 8'h16;
    localparam logic [7:0] DIR_U = 8'h1A;
    localparam logic [7:0] DIR_0 = 8'h00;

    localparam logic [10:0] SC_LOAD   = 11'(SCATTER_FRAMES - 1);
    localparam logic [10:0] CH_LOAD   = 11'(CHASE_FRAMES - 1);
    localparam logic [7:0]  HOLD_LOAD = 8'(HOLD_FRAMES - 1);

    mode_t       state;
    logic [10:0] phase_cnt;
    logic [7:0]  hold_cnt;

    assign mode = state;

    function automatic logic [7:0] rev_dir(input logic [7:0] d);
        case (d)
            DIR_L:   return DIR_R;
            DIR_R:   return DIR_L;
            DIR_D:   return DIR_U;
            DIR_U:   return DIR_D;
            default: return DIR_0;
        endcase
    endfunction

    // blk = {left, right, up, down}
    function automatic logic hits_wall(input logic [7:0] d,
                                       input logic [3:0] blk);
        case (d)
            DIR_L:   return blk[3];
            DIR_R:   return blk[2];
            DIR_U:   return blk[1];
            DIR_D:   return blk[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [10:0] abs11(input logic [10:0] v);
        return v[10] ? (~v + 11'd1) : v;
    endfunction

    logic [10:0] gx, gy, gs;
    logic [10:0] tx, ty;
    logic [10:0] dx, dy, adx, ady;
    logic [10:0] cdx, cdy;
    logic [3:0]  blk;
    logic        catch_now;

    assign gx = {1'b0, ghostX};
    assign gy = {1'b0, ghostY};
    assign gs = {1'b0, ghostS};

    assign tx = (state == CHASE) ? {1'b0, pacX} : 11'(CORNER_X);
    assign ty = (state == CHASE) ? {1'b0, pacY} : 11'(CORNER_Y);

    assign dx  = tx - gx;
    assign dy  = ty - gy;
    assign adx = abs11(dx);
    assign ady = abs11(dy);

    // Compare with the half-size moved to the other side so nothing underflows
    assign blk[3] = gx <= 11'(X_MIN) + gs;
    assign blk[2] = gx + gs >= 11'(X_MAX);
    assign blk[1] = gy <= 11'(Y_MIN) + gs;
    assign blk[0] = gy + gs >= 11'(Y_MAX);

    assign cdx       = abs11({1'b0, pacX} - gx);
    assign cdy       = abs11({1'b0, pacY} - gy);
    assign catch_now = (cdx < gs) && (cdy < gs);

    logic [7:0] cand_x, cand_y, prim, sec;
    logic [7:0] rev_cur, sel, flip;
    logic [7:0] hold_dec;

    assign hold_dec = (hold_cnt == 8'd0) ? 8'd0 : hold_cnt - 8'd1;

    always_comb begin
        cand_x  = DIR_0;
        cand_y  = DIR_0;
        prim    = DIR_0;
        sec     = DIR_0;
        sel     = DIR_0;
        rev_cur = rev_dir(dir_code);
        flip    = DIR_0;

        if (dx != 11'd0) cand_x = dx[10] ? DIR_L : DIR_R;
        if (dy != 11'd0) cand_y = dy[10] ? DIR_U : DIR_D;

        if (adx >= ady) begin
            prim = cand_x;
            sec  = cand_y;
        end else begin
            prim = cand_y;
            sec  = cand_x;
        end

        if (prim != DIR_0 && prim != rev_cur && !hits_wall(prim, blk))
            sel = prim;
        else if (sec != DIR_0 && sec != rev_cur && !hits_wall(sec, blk))
            sel = sec;
        else if (dir_code != DIR_0 && !hits_wall(dir_code, blk))
            sel = dir_code;

        if (!hits_wall(rev_cur, blk)) flip = rev_cur;
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state     <= IDLE;
            dir_code  <= DIR_0;
            catch     <= 1'b0;
            hold_cnt  <= 8'd0;
            phase_cnt <= 11'd0;
        end else if (!enable) begin
            state     <= IDLE;
            dir_code  <= DIR_0;
            catch     <= 1'b0;
            hold_cnt  <= 8'd0;
            phase_cnt <= 11'd0;
        end else begin
            catch <= catch_now;
            if (state == IDLE) begin
                state     <= SCATTER;
                phase_cnt <= SC_LOAD;
                dir_code  <= sel;
                hold_cnt  <= (sel != DIR_0) ? HOLD_LOAD : 8'd0;
            end else if (catch_now) begin
                dir_code <= DIR_0;
                hold_cnt <= (dir_code != DIR_0) ? HOLD_LOAD : hold_dec;
            end else if (phase_cnt == 11'd0) begin
                // Mode flip: turn around regardless of hold
                state     <= (state == SCATTER) ? CHASE : SCATTER;
                phase_cnt <= (state == SCATTER) ? CH_LOAD : SC_LOAD;
                dir_code  <= flip;
                hold_cnt  <= HOLD_LOAD;
            end else begin
                phase_cnt <= phase_cnt - 11'd1;
                if (hold_cnt == 8'd0 && sel != dir_code) begin
                    dir_code <= sel;
                    hold_cnt <= HOLD_LOAD;
                end else begin
                    hold_cnt <= hold_dec;
                end
            end
        end
    end

endmodule

// File: tb/tb_ghost_chase_ctrl.sv
// Bench for ghost_chase_ctrl: directed scenarios plus randomized frames
// compared every edge against a frame-count based behavioural model.
module tb_ghost_chase_ctrl;

    localparam int SF   = 420;
    localparam int CF   = 1200;
    localparam int HOLD = 8;

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b1;
    logic       enable = 1'b0;
    logic [9:0] pacX = '0, pacY = '0;
    logic [9:0] ghostX = '0, ghostY = '0, ghostS = '0;
    logic [7:0] dir_code;
    logic [1:0] mode;
    logic       catch;

    ghost_chase_ctrl dut (
        .frame_clk(frame_clk),
        .Reset    (Reset),
        .enable   (enable),
        .pacX     (pacX),
        .pacY     (pacY),
        .ghostX   (ghostX),
        .ghostY   (ghostY),
        .ghostS   (ghostS),
        .dir_code (dir_code),
        .mode     (mode),
        .catch    (catch)
    );

    always #5 frame_clk = ~frame_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state: mode, frames spent in current phase, last turn frame
    int e_mode  = 0;
    int e_dir   = 0;
    int e_catch = 0;
    int done    = 0;
    int last_ch = -1000;
    int frame_n = 0;

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    function automatic int rev(input int d);
        case (d)
            'h04: return 'h07;
            'h07: return 'h04;
            'h16: return 'h1A;
            'h1A: return 'h16;
            default: return 0;
        endcase
    endfunction

    function automatic bit wall(input int d, input int gx, input int gy,
                                input int gs);
        case (d)
            'h04: return gx - gs <= 7;
            'h07: return gx + gs >= 396;
            'h1A: return gy - gs <= 7;
            'h16: return gy + gs >= 440;
            default: return 0;
        endcase
    endfunction

    function automatic int pick(input int tx, input int ty, input int gx,
                                input int gy, input int gs, input int cur);
        int dx, dy, cx, cy, p, s;
        dx = tx - gx;
        dy = ty - gy;
        cx = dx > 0 ? 'h07 : (dx < 0 ? 'h04 : 0);
        cy = dy > 0 ? 'h16 : (dy < 0 ? 'h1A : 0);
        if (iabs(dx) >= iabs(dy)) begin p = cx; s = cy; end
        else begin p = cy; s = cx; end
        if (p != 0 && p != rev(cur) && !wall(p, gx, gy, gs)) return p;
        if (s != 0 && s != rev(cur) && !wall(s, gx, gy, gs)) return s;
        if (cur != 0 && !wall(cur, gx, gy, gs)) return cur;
        return 0;
    endfunction

    task automatic model_step();
        int gx, gy, gs, px, py, nd;
        bit c;
        gx = int'(ghostX); gy = int'(ghostY); gs = int'(ghostS);
        px = int'(pacX);   py = int'(pacY);
        frame_n++;
        if (Reset || !enable) begin
            e_mode = 0; e_dir = 0; e_catch = 0; done = 0; last_ch = -1000;
        end else begin
            c = (iabs(px - gx) < gs) && (iabs(py - gy) < gs);
            e_catch = c;
            if (e_mode == 0) begin
                e_mode = 1;
                done = 1;
                nd = pick(396, 7, gx, gy, gs, 0);
                if (nd != 0) last_ch = frame_n;
                e_dir = nd;
            end else if (c) begin
                if (e_dir != 0) last_ch = frame_n;
                e_dir = 0;
            end else if (done == (e_mode == 1 ? SF : CF)) begin
                e_mode = 3 - e_mode;
                done = 1;
                nd = rev(e_dir);
                e_dir = wall(nd, gx, gy, gs) ? 0 : nd;
                last_ch = frame_n;
            end else begin
                done++;
                if (e_mode == 1) nd = pick(396, 7, gx, gy, gs, e_dir);
                else nd = pick(px, py, gx, gy, gs, e_dir);
                if (nd != e_dir && frame_n - last_ch >= HOLD) begin
                    e_dir = nd;
                    last_ch = frame_n;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge frame_clk);
        #1;
        chk("dir", int'(dir_code), e_dir);
        chk("mode", int'(mode), e_mode);
        chk("catch", int'(catch), e_catch);
    endtask

    task automatic set_pos(input int gx, input int gy, input int gs,
                           input int px, input int py);
        ghostX = 10'(gx); ghostY = 10'(gy); ghostS = 10'(gs);
        pacX = 10'(px);   pacY = 10'(py);
    endtask

    initial begin
        int gx, gy;
        Reset = 1'b1;
        enable = 1'b1;
        set_pos(50, 50, 10, 300, 400);
        tick();
        chk("rst_mode", int'(mode), 0);
        chk("rst_dir", int'(dir_code), 0);
        chk("rst_catch", int'(catch), 0);

        Reset = 1'b0;
        tick();
        chk("enter_mode", int'(mode), 1);
        chk("enter_dir", int'(dir_code), 'h07);
        repeat (SF - 1) tick();
        chk("scatter_len", int'(mode), 1);
        tick();
        chk("chase_at_421", int'(mode), 2);
        chk("flip_dir", int'(dir_code), 'h04);
        repeat (7) tick();
        chk("flip_hold", int'(dir_code), 'h04);
        tick();
        chk("hold_expire", int'(dir_code), 'h16);

        set_pos(200, 200, 10, 300, 200);
        repeat (8) tick();
        chk("go_right", int'(dir_code), 'h07);
        set_pos(200, 200, 10, 100, 260);
        repeat (8) tick();
        chk("no_reverse", int'(dir_code), 'h16);

        set_pos(100, 100, 10, 105, 103);
        repeat (5) begin
            tick();
            chk("catch_on", int'(catch), 1);
            chk("catch_dir", int'(dir_code), 0);
            chk("catch_mode", int'(mode), 2);
        end
        set_pos(100, 100, 10, 130, 100);
        tick();
        chk("catch_off", int'(catch), 0);

        set_pos(17, 100, 10, 0, 100);
        tick();
        chk("wall_stop", int'(dir_code), 0);
        repeat (1300) tick();

        for (int i = 0; i < 3000; i++) begin
            Reset  = ($urandom_range(0, 499) == 0);
            enable = ($urandom_range(0, 999) != 0);
            gx = $urandom_range(0, 460);
            gy = $urandom_range(0, 460);
            ghostX = 10'(gx);
            ghostY = 10'(gy);
            ghostS = 10'($urandom_range(1, 24));
            if ($urandom_range(0, 19) == 0) begin
                pacX = 10'(gx + $urandom_range(0, 12));
                pacY = 10'(gy + $urandom_range(0, 12));
            end else begin
                pacX = 10'($urandom_range(0, 1023));
                pacY = 10'($urandom_range(0, 1023));
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ghost_chase_ctrl.md
# ghost_chase_ctrl

Per-frame ghost steering controller. Consumes Pac-Man and ghost positions and produces the direction command (same keycode encoding the ghost mover decodes) that drives a ghost's motion. It runs a scatter/chase mode timer, enforces a no-reverse rule and a minimum hold time between turns, and flags a catch when the ghost overlaps Pac-Man. It sits between the position producers (Pac-Man and ghost modules) and the ghost mover's direction input.

## Interface
- SCATTER_FRAMES, 420, frames spent in SCATTER before switching to CHASE
- CHASE_FRAMES, 1200, frames spent in CHASE before switching to SCATTER
- HOLD_FRAMES, 8, minimum frames between ordinary direction changes (≥1)
- CORNER_X, 396, scatter target X
- CORNER_Y, 7, scatter target Y
- X_MIN / X_MAX / Y_MIN / Y_MAX, 7 / 396 / 7 / 440, maze borders
- frame_clk  in  1  the only clock; one edge = one frame
- Reset  in  1  synchronous, active-high
- enable  in  1  game running; low freezes the controller in IDLE
- pacX, pacY  in  10 each  Pac-Man centre
- ghostX, ghostY  in  10 each  ghost centre
- ghostS  in  10  ghost half-size
- dir_code  out  8  8'h04 left, 8'h07 right, 8'h16 down, 8'h1A up, 8'h00 stop
- mode  out  2  0 IDLE, 1 SCATTER, 2 CHASE
- catch  out  1  ghost overlaps Pac-Man

## Operation
- Mode FSM:
  - IDLE → SCATTER when enable=1; phase counter loads SCATTER_FRAMES-1.
  - SCATTER → CHASE when the counter is 0 (load CHASE_FRAMES-1).
  - CHASE → SCATTER when the counter is 0 (load SCATTER_FRAMES-1).
  - Any state → IDLE when enable=0; in IDLE dir_code=00, counters cleared.
- Target: (CORNER_X, CORNER_Y) in SCATTER; (pacX, pacY) in CHASE.
- Deltas: dx = target − ghostX and dy = target − ghostY, as 11-bit signed values (zero-extend operands, no wrap). Use |dx| and |dy|.
- Primary axis is the one with the larger magnitude; a tie selects X. Secondary is the other axis.
  - Direction follows the sign of the delta: positive dx → right, positive dy → down.
  - An axis with delta 0 yields no candidate.
- Blocked candidates:
  - A candidate is blocked if it is the exact reverse of the current dir_code.
  - A candidate is also blocked if it hits a wall:
    - left: ghostX − ghostS ≤ X_MIN
    - right: ghostX + ghostS ≥ X_MAX
    - up: ghostY − ghostS ≤ Y_MIN
    - down: ghostY + ghostS ≥ Y_MAX
  - Wall compares use 11-bit arithmetic, so the subtraction never underflows.
- Selection:
  - Take the primary candidate if unblocked; otherwise the secondary if unblocked.
  - Otherwise keep the current dir_code if it is not wall-blocked; otherwise 00.
- Hold:
  - A change of dir_code is allowed only when hold_cnt = 0.
  - On a change, hold_cnt loads HOLD_FRAMES-1; otherwise it decrements and saturates at 0.
  - Changes to 00 are also held.
- Mode-switch reversal: on the frame the FSM moves SCATTER↔CHASE, dir_code is forced to the reverse of the current direction (00 stays 00).
  - This bypasses the hold and the no-reverse rule, but not walls: if the reverse is wall-blocked, output 00.
  - hold_cnt reloads.
- Catch:
  - catch = enable & (|pacX−ghostX| < ghostS) & (|pacY−ghostY| < ghostS).
  - While catch=1: dir_code=00, the phase counter is frozen and the mode is held.
  - catch has no effect in IDLE.

## Timing
- All outputs are registered on frame_clk. Inputs sampled at edge N appear on the outputs after edge N, giving 1-frame latency.
- Reset (synchronous, dominates enable): mode=0, dir_code=8'h00, catch=0, hold_cnt=0, phase counter=0.
- Reset held mid-game clears all state on the next edge. The FSM re-enters SCATTER on the first edge with Reset=0 and enable=1, and dir_code leaves 00 on that same edge.
- First direction after leaving IDLE is not subject to the hold and has no reverse restriction, because the current dir_code is 00.
- SCATTER lasts exactly SCATTER_FRAMES edges and CHASE exactly CHASE_FRAMES edges, excluding frames with catch=1.
- Simultaneous mode switch and catch: catch wins; the switch is deferred until catch drops.
- enable falling: IDLE and dir_code=00 on the same edge.

## Test plan
- Reset then enable=1, ghost (50,50), S=10, pac far → mode=1 after 1 edge, dir_code=8'h07 (dx=346 > dy=−43). mode=2 on edge 421.
- CHASE, ghost (200,200), pac (100,260), current dir right → primary left is a reverse, so dir_code=8'h16 (down).
- HOLD_FRAMES=8, target moved every frame to force alternate picks → dir_code changes no more often than once per 8 edges.
- Ghost (17,100), S=10, target (0,100) → left is wall-blocked, dy=0 → dir_code=8'h00.
- SCATTER→CHASE transition with dir 8'h07, hold_cnt=5 → dir_code=8'h04 on the transition edge and hold_cnt reloads to 7.
- pac (105,103), ghost (100,100), S=10 → catch=1, dir_code=00, and the phase counter holds its value over 5 frames. Moving pac to (130,100) → catch=0 next edge and counting resumes.
